seg7_scan: RTL

Multiplexed seven-segment display scanner that consumes the one-cycle scan pulse produced by the board clock divider (nominally 200 Hz from the 100 MHz system clock). On each pulse it advances to the next digit, inserts an anti-ghosting blank interval, then drives one active-low anode with the hex-decoded segment pattern for that digit's nibble. The displayed value is snapshotted once per full frame so that digits within a frame are always coherent. It sits between the CPU debug/output register and the board LED pins.

---
 rtl/seg7_scan.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed seven-segment scanner with anti-ghost blanking
// Optional macro SEG7_LEADING_ZERO_BLANK_EN darkens leading zero digits
module seg7_scan #(
  parameter int DIGITS       = 8,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic [15:0] CNT_LOAD = 16'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  state_t state;
  state_t state_n;

  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_n;
  logic [IW-1:0]       idx_inc;
  logic [15:0]         cnt;
  logic [15:0]         cnt_n;
  logic [4*DIGITS-1:0] sh_val;
  logic [4*DIGITS-1:0] sh_val_n;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   sh_dp_n;
  logic [DIGITS-1:0]   an_n;
  logic [7:0]          seg_n;

  logic [3:0]          nib;
  logic                nib_dp;
  logic [DIGITS-1:0]   sel_an;
  logic                dark;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Select the current digit's shadow nibble, dp bit and anode
  always_comb begin
    nib    = 4'h0;
    nib_dp = 1'b0;
    sel_an = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib       = sh_val[4*i +: 4];
        nib_dp    = sh_dp[i];
        sel_an[i] = 1'b0;
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz;
  logic              run;

  // Digit is dark when it and every higher digit hold zero
  always_comb begin
    lz   = '0;
    run  = 1'b1;
    dark = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run   = run & (sh_val[4*i +: 4] == 4'h0);
      lz[i] = run & (i > 0);
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        dark = lz[i];
      end
    end
  end
`else
  // Every digit is decoded, leading zeros included
  always_comb begin
    dark = 1'b0;
  end
`endif

  // Next digit index with wrap to digit 0
  always_comb begin
    idx_inc = (idx == LAST) ? '0 : idx + 1'b1;
  end

  // Next-state and registered-output logic; tick beats the countdown
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    cnt_n    = cnt;
    sh_val_n = sh_val;
    sh_dp_n  = sh_dp;
    an_n     = an;
    seg_n    = seg;
    if (tick) begin
      idx_n   = idx_inc;
      if (idx_inc == '0) begin
        sh_val_n = value;
        sh_dp_n  = dp;
      end
      state_n = BLANK;
      cnt_n   = CNT_LOAD;
      an_n    = '1;
      seg_n   = 8'hFF;
    end else begin
      unique case (state)
        IDLE: begin
          an_n  = '1;
          seg_n = 8'hFF;
        end
        BLANK: begin
          if (cnt != 16'd0) begin
            cnt_n = cnt - 16'd1;
          end else begin
            state_n = SHOW;
            an_n    = sel_an;
            seg_n   = {~nib_dp, dark ? 7'h7F : hex7(nib)};
          end
        end
        SHOW: begin
          state_n = SHOW;
        end
        default: begin
          state_n = IDLE;
          an_n    = '1;
          seg_n   = 8'hFF;
        end
      endcase
    end
  end

  // State, snapshot and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= LAST;
      cnt    <= '0;
      sh_val <= '0;
      sh_dp  <= '0;
      an     <= '1;
      seg    <= 8'hFF;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      cnt    <= cnt_n;
      sh_val <= sh_val_n;
      sh_dp  <= sh_dp_n;
      an     <= an_n;
      seg    <= seg_n;
    end
  end

endmodule
